// File: rtl/mbc_pkg.sv
// Shared constants for the basic-computer control sequencer: ALU operation
// codes, memory-reference opcodes and common-bus source selects.
package mbc_pkg;

  // ALU operation codes driven on alu_code
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0001;
  localparam logic [3:0] ALU_LDA = 4'b0010;
  localparam logic [3:0] ALU_CMA = 4'b0011;
  localparam logic [3:0] ALU_CIR = 4'b0100;
  localparam logic [3:0] ALU_CIL = 4'b0101;
  localparam logic [3:0] ALU_INC = 4'b0110;
  localparam logic [3:0] ALU_CLA = 4'b0111;
  localparam logic [3:0] ALU_CLE = 4'b1000;
  localparam logic [3:0] ALU_CME = 4'b1001;
  localparam logic [3:0] ALU_NOP = 4'b1100;

  // Instruction opcode field ir[14:12]; 7 selects register-reference / I/O
  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ADD = 3'd1,
    OP_LDA = 3'd2,
    OP_STA = 3'd3,
    OP_BUN = 3'd4,
    OP_BSA = 3'd5,
    OP_ISZ = 3'd6,
    OP_RR  = 3'd7
  } opcode_e;

  // Common-bus source selects
  localparam logic [2:0] BUS_NONE = 3'd0;
  localparam logic [2:0] BUS_AR   = 3'd1;
  localparam logic [2:0] BUS_PC   = 3'd2;
  localparam logic [2:0] BUS_DR   = 3'd3;
  localparam logic [2:0] BUS_AC   = 3'd4;
  localparam logic [2:0] BUS_IR   = 3'd5;
  localparam logic [2:0] BUS_MEM  = 3'd7;

endpackage

// File: rtl/mbc_rr_decode.sv
// Register-reference instruction decoder. Only the highest-numbered set bit
// of the 12-bit field executes; an all-zero field is a NOP.
module mbc_rr_decode
  import mbc_pkg::*;
(
  input  logic [11:0] rr,
  input  logic        ac_sign,
  input  logic        ac_zero,
  input  logic        e_flag,
  output logic [3:0]  alu_code,
  output logic        ac_ld,
  output logic        e_ld,
  output logic        pc_inc,
  output logic        hlt
);

  // Priority decode from bit 11 (CLA) down to bit 0 (HLT)
  always_comb begin
    alu_code = ALU_NOP;
    ac_ld    = 1'b0;
    e_ld     = 1'b0;
    pc_inc   = 1'b0;
    hlt      = 1'b0;
    if (rr[11]) begin
      alu_code = ALU_CLA;
      ac_ld    = 1'b1;
    end else if (rr[10]) begin
      alu_code = ALU_CLE;
      e_ld     = 1'b1;
    end else if (rr[9]) begin
      alu_code = ALU_CMA;
      ac_ld    = 1'b1;
    end else if (rr[8]) begin
      alu_code = ALU_CME;
      e_ld     = 1'b1;
    end else if (rr[7]) begin
      alu_code = ALU_CIR;
      ac_ld    = 1'b1;
      e_ld     = 1'b1;
    end else if (rr[6]) begin
      alu_code = ALU_CIL;
      ac_ld    = 1'b1;
      e_ld     = 1'b1;
    end else if (rr[5]) begin
      alu_code = ALU_INC;
      ac_ld    = 1'b1;
    end else if (rr[4]) begin
      pc_inc   = ~ac_sign;
    end else if (rr[3]) begin
      pc_inc   = ac_sign;
    end else if (rr[2]) begin
      pc_inc   = ac_zero;
    end else if (rr[1]) begin
      pc_inc   = ~e_flag;
    end else if (rr[0]) begin
      hlt      = 1'b1;
    end
  end

endmodule

// File: rtl/mbc_control_seq.sv
// Timing-and-control sequencer for the basic computer: fetch, decode,
// indirect and execute cycles, producing ALU codes, register strobes,
// memory strobes and the common-bus select.
// Optional build macro MBC_STEP_EN adds a single-step input that holds the
// sequencer at T0 between instructions until step is sampled high.
module mbc_control_seq
  import mbc_pkg::*;
#(
  parameter int SC_W   = 3,
  parameter int ADDR_W = 12
) (
  input  logic            clk,
  input  logic            rst,
`ifdef MBC_STEP_EN
  input  logic            step,
`endif
  input  logic [15:0]     ir,
  input  logic            ac_sign,
  input  logic            ac_zero,
  input  logic            e_flag,
  input  logic            dr_zero,
  output logic [3:0]      alu_code,
  output logic            ac_ld,
  output logic            e_ld,
  output logic            dr_ld,
  output logic            dr_inc,
  output logic            ar_ld,
  output logic            ar_inc,
  output logic            pc_ld,
  output logic            pc_inc,
  output logic            ir_ld,
  output logic            mem_rd,
  output logic            mem_wr,
  output logic [2:0]      bus_sel,
  output logic [SC_W-1:0] sc,
  output logic            halted
);

  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  logic    ind;
  opcode_e opcode;
  logic    active;
  logic    done;
  logic    hlt_exec;

  logic [3:0] rr_alu;
  logic       rr_ac_ld;
  logic       rr_e_ld;
  logic       rr_pc_inc;
  logic       rr_hlt;

  mbc_rr_decode u_rr_decode (
    .rr       (ir[ADDR_W-1:0]),
    .ac_sign  (ac_sign),
    .ac_zero  (ac_zero),
    .e_flag   (e_flag),
    .alu_code (rr_alu),
    .ac_ld    (rr_ac_ld),
    .e_ld     (rr_e_ld),
    .pc_inc   (rr_pc_inc),
    .hlt      (rr_hlt)
  );

`ifdef MBC_STEP_EN
  logic idle;
  // Between instructions the sequencer waits at T0 until step is seen.
  assign active = ~rst & ~halted & (~idle | step);
`else
  assign active = ~rst & ~halted;
`endif

  assign hlt_exec = active && (sc == T3) && (opcode == OP_RR) && !ind && rr_hlt;

  // Decode strobes, ALU code and bus select from the current timing state
  always_comb begin
    alu_code = ALU_NOP;
    ac_ld    = 1'b0;
    e_ld     = 1'b0;
    dr_ld    = 1'b0;
    dr_inc   = 1'b0;
    ar_ld    = 1'b0;
    ar_inc   = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    bus_sel  = BUS_NONE;
    done     = 1'b0;
    if (active) begin
      case (sc)
        T0: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        T1: begin
          bus_sel = BUS_MEM;
          mem_rd  = 1'b1;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        T2: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
        end
        T3: begin
          if (opcode == OP_RR) begin
            done = 1'b1;
            // I=1 with opcode 7 is I/O, handled as a NOP here
            if (!ind) begin
              alu_code = rr_alu;
              ac_ld    = rr_ac_ld;
              e_ld     = rr_e_ld;
              pc_inc   = rr_pc_inc;
            end
          end else if (ind) begin
            bus_sel = BUS_MEM;
            mem_rd  = 1'b1;
            ar_ld   = 1'b1;
          end
        end
        T4: begin
          case (opcode)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              mem_rd  = 1'b1;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
              done    = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              done    = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: done = 1'b1;
          endcase
        end
        T5: begin
          case (opcode)
            OP_AND: begin
              alu_code = ALU_AND;
              ac_ld    = 1'b1;
              done     = 1'b1;
            end
            OP_ADD: begin
              alu_code = ALU_ADD;
              ac_ld    = 1'b1;
              e_ld     = 1'b1;
              done     = 1'b1;
            end
            OP_LDA: begin
              alu_code = ALU_LDA;
              ac_ld    = 1'b1;
              done     = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              done    = 1'b1;
            end
            OP_ISZ: dr_inc = 1'b1;
            default: done = 1'b1;
          endcase
        end
        T6: begin
          done = 1'b1;
          if (opcode == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
          end
        end
        // Unreachable states fall back to T0 rather than overflowing
        default: done = 1'b1;
      endcase
    end
  end

  // Sequence counter, halt flag and instruction-field latch
  always_ff @(posedge clk) begin
    if (rst) begin
      sc     <= T0;
      halted <= 1'b0;
      ind    <= 1'b0;
      opcode <= OP_AND;
`ifdef MBC_STEP_EN
      idle   <= 1'b0;
`endif
    end else if (halted) begin
      sc <= T0;
    end else if (active) begin
      if (sc == T2) begin
        ind    <= ir[15];
        opcode <= opcode_e'(ir[14:12]);
      end
      if (hlt_exec) halted <= 1'b1;
      sc <= done ? T0 : sc + T1;
`ifdef MBC_STEP_EN
      idle <= done;
`endif
    end
  end

endmodule

// File: tb/tb_mbc_control_seq.sv
// Directed bench for mbc_control_seq: each cycle's expected output vector is
// queued as the stimulus is applied and checked at the following falling edge.
module tb_mbc_control_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ir = 16'h0000;
  logic        ac_sign = 1'b0;
  logic        ac_zero = 1'b0;
  logic        e_flag = 1'b0;
  logic        dr_zero = 1'b0;
`ifdef MBC_STEP_EN
  logic        step = 1'b1;
`endif

  logic [3:0] alu_code;
  logic       ac_ld, e_ld, dr_ld, dr_inc, ar_ld, ar_inc, pc_ld, pc_inc, ir_ld, mem_rd, mem_wr;
  logic [2:0] bus_sel;
  logic [2:0] sc;
  logic       halted;

  mbc_control_seq dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MBC_STEP_EN
    .step     (step),
`endif
    .ir       (ir),
    .ac_sign  (ac_sign),
    .ac_zero  (ac_zero),
    .e_flag   (e_flag),
    .dr_zero  (dr_zero),
    .alu_code (alu_code),
    .ac_ld    (ac_ld),
    .e_ld     (e_ld),
    .dr_ld    (dr_ld),
    .dr_inc   (dr_inc),
    .ar_ld    (ar_ld),
    .ar_inc   (ar_inc),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .ir_ld    (ir_ld),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .bus_sel  (bus_sel),
    .sc       (sc),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // Strobe masks, in the order ac_ld e_ld dr_ld dr_inc ar_ld ar_inc pc_ld pc_inc ir_ld mem_rd mem_wr
  localparam logic [10:0] S_NO   = 11'b000_0000_0000;
  localparam logic [10:0] S_AC   = 11'b100_0000_0000;
  localparam logic [10:0] S_E    = 11'b010_0000_0000;
  localparam logic [10:0] S_DRLD = 11'b001_0000_0000;
  localparam logic [10:0] S_DRIN = 11'b000_1000_0000;
  localparam logic [10:0] S_ARLD = 11'b000_0100_0000;
  localparam logic [10:0] S_ARIN = 11'b000_0010_0000;
  localparam logic [10:0] S_PCLD = 11'b000_0001_0000;
  localparam logic [10:0] S_PCIN = 11'b000_0000_1000;
  localparam logic [10:0] S_IRLD = 11'b000_0000_0100;
  localparam logic [10:0] S_RD   = 11'b000_0000_0010;
  localparam logic [10:0] S_WR   = 11'b000_0000_0001;

  localparam logic [2:0] B_NONE = 3'd0, B_AR = 3'd1, B_PC = 3'd2, B_DR = 3'd3;
  localparam logic [2:0] B_AC = 3'd4, B_IR = 3'd5, B_MEM = 3'd7;

  localparam logic [3:0] A_AND = 4'b0000, A_ADD = 4'b0001, A_LDA = 4'b0010;
  localparam logic [3:0] A_CIL = 4'b0101, A_CLA = 4'b0111, A_NOP = 4'b1100;

  typedef struct {
    string       tag;
    logic [21:0] val;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  wire [21:0] obs = {alu_code, ac_ld, e_ld, dr_ld, dr_inc, ar_ld, ar_inc, pc_ld, pc_inc,
                     ir_ld, mem_rd, mem_wr, bus_sel, sc, halted};

  function automatic logic [21:0] ex(input logic [2:0] s, input logic [2:0] b,
                                     input logic [3:0] a, input logic [10:0] st,
                                     input logic h);
    return {a, st, b, s, h};
  endfunction

  // Queue the expectation for the current cycle, then check it mid-cycle
  task automatic chk(input string tag, input logic [21:0] e);
    exp_t x;
    exp_t y;
    x.tag = tag;
    x.val = e;
    sb.push_back(x);
    @(negedge clk);
    y = sb.pop_front();
    total++;
    assert (obs === y.val) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", y.tag, obs, y.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string t);
    chk({t, "_t0"}, ex(3'd0, B_PC,  A_NOP, S_ARLD, 1'b0));
    chk({t, "_t1"}, ex(3'd1, B_MEM, A_NOP, S_RD | S_IRLD | S_PCIN, 1'b0));
    chk({t, "_t2"}, ex(3'd2, B_IR,  A_NOP, S_ARLD, 1'b0));
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", ex(3'd0, B_NONE, A_NOP, S_NO, 1'b0));
    rst = 1'b0;

    // ADD direct
    ir = 16'h1005;
    fetch("add");
    chk("add_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("add_t4", ex(3'd4, B_MEM, A_NOP, S_RD | S_DRLD, 1'b0));
    chk("add_t5", ex(3'd5, B_NONE, A_ADD, S_AC | S_E, 1'b0));

    // AND indirect
    ir = 16'h8005;
    fetch("and");
    chk("and_t3", ex(3'd3, B_MEM, A_NOP, S_RD | S_ARLD, 1'b0));
    chk("and_t4", ex(3'd4, B_MEM, A_NOP, S_RD | S_DRLD, 1'b0));
    chk("and_t5", ex(3'd5, B_NONE, A_AND, S_AC, 1'b0));

    // LDA direct
    ir = 16'h2005;
    fetch("lda");
    chk("lda_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("lda_t4", ex(3'd4, B_MEM, A_NOP, S_RD | S_DRLD, 1'b0));
    chk("lda_t5", ex(3'd5, B_NONE, A_LDA, S_AC, 1'b0));

    // STA, BUN, BSA
    ir = 16'h3005;
    fetch("sta");
    chk("sta_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("sta_t4", ex(3'd4, B_AC, A_NOP, S_WR, 1'b0));
    ir = 16'h4005;
    fetch("bun");
    chk("bun_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("bun_t4", ex(3'd4, B_AR, A_NOP, S_PCLD, 1'b0));
    ir = 16'h5005;
    fetch("bsa");
    chk("bsa_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("bsa_t4", ex(3'd4, B_PC, A_NOP, S_WR | S_ARIN, 1'b0));
    chk("bsa_t5", ex(3'd5, B_AR, A_NOP, S_PCLD, 1'b0));

    // Skip instructions and a circulate
    ir = 16'h7010; ac_sign = 1'b0;
    fetch("spa0");
    chk("spa0_t3", ex(3'd3, B_NONE, A_NOP, S_PCIN, 1'b0));
    ir = 16'h7010; ac_sign = 1'b1;
    fetch("spa1");
    chk("spa1_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    ir = 16'h7008;
    fetch("sna");
    chk("sna_t3", ex(3'd3, B_NONE, A_NOP, S_PCIN, 1'b0));
    ir = 16'h7002; e_flag = 1'b1;
    fetch("sze");
    chk("sze_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    ir = 16'h7040;
    fetch("cil");
    chk("cil_t3", ex(3'd3, B_NONE, A_CIL, S_AC | S_E, 1'b0));

    // I/O instruction acts as a NOP
    ir = 16'hF800;
    fetch("io");
    chk("io_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));

    // ISZ with and without a zero result
    ir = 16'h6020; dr_zero = 1'b1;
    fetch("isz1");
    chk("isz1_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("isz1_t4", ex(3'd4, B_MEM, A_NOP, S_RD | S_DRLD, 1'b0));
    chk("isz1_t5", ex(3'd5, B_NONE, A_NOP, S_DRIN, 1'b0));
    chk("isz1_t6", ex(3'd6, B_DR, A_NOP, S_WR | S_PCIN, 1'b0));
    dr_zero = 1'b0;
    fetch("isz0");
    chk("isz0_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    chk("isz0_t4", ex(3'd4, B_MEM, A_NOP, S_RD | S_DRLD, 1'b0));
    chk("isz0_t5", ex(3'd5, B_NONE, A_NOP, S_DRIN, 1'b0));
    chk("isz0_t6", ex(3'd6, B_DR, A_NOP, S_WR, 1'b0));

    // Reset during ISZ T4 abandons the instruction
    fetch("iszr");
    chk("iszr_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    rst = 1'b1;
    chk("iszr_rst", ex(3'd4, B_NONE, A_NOP, S_NO, 1'b0));
    rst = 1'b0;
    ir = 16'h7A00;
    fetch("cla");
    chk("cla_t3", ex(3'd3, B_NONE, A_CLA, S_AC, 1'b0));

    // HLT freezes the sequencer until reset
    ir = 16'h7001;
    fetch("hlt");
    chk("hlt_t3", ex(3'd3, B_NONE, A_NOP, S_NO, 1'b0));
    for (int i = 0; i < 10; i++) chk("halted", ex(3'd0, B_NONE, A_NOP, S_NO, 1'b1));
    rst = 1'b1;
    chk("hlt_rst", ex(3'd0, B_NONE, A_NOP, S_NO, 1'b1));
    rst = 1'b0;
    fetch("post");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
